pixel_stream_unpacker: RTL and testbench

- Receive end of the pixel generator's 32-bit AXI4-Stream video output: accepts packed 24-bit RGB words and unpacks them into one pixel per handshake, with (x, y) coordinates.
- Checks frame structure: SOF on `tuser`, EOL on `tlast`, and `tkeep`.
- Sits between the generator's stream port and the display/test sinks; used as the in-fabric checker in simulation.

---
 rtl/pixel_stream_unpacker.sv | 246 ++++++++++++++++++++++++
 tb/tb_pixel_stream_unpacker.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
// Receives 32-bit AXI4-Stream words carrying packed 24-bit RGB (4 pixels in
// 3 words), emits one pixel per handshake with (x, y) coordinates, and checks
// the frame structure (SOF on tuser, EOL on tlast, tkeep).
// Optional feature: define PIXEL_UNPACK_CHECKSUM_EN to build the per-frame
// pixel checksum on frame_sum; otherwise frame_sum is tied to 0.
module pixel_stream_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    input  logic        err_clr,
    output logic [3:0]  err_status,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [31:0] frame_sum
);

    localparam int              W_LAST  = (3 * X_SIZE) / 4 - 1;
    localparam int              WX_W    = $clog2(W_LAST + 1);
    localparam logic [WX_W-1:0] WX_LAST = WX_W'(W_LAST);
    localparam logic [9:0]      X_LAST  = 10'(X_SIZE - 1);
    localparam logic [8:0]      Y_LAST  = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {P0, P1, P2, EMIT3} phase_t;

    // Line advance with wrap at the last line of the frame.
    function automatic logic [8:0] next_y(input logic [8:0] y);
        return (y == Y_LAST) ? 9'd0 : y + 9'd1;
    endfunction

    phase_t          r_phase, w_phase_nxt, w_ph;
    logic [WX_W-1:0] r_word_x, w_wx_nxt, w_wx;
    logic [9:0]      r_x, w_x_nxt, w_cx, w_ld_x;
    logic [8:0]      r_y, w_y_nxt, w_cy, w_ld_y;
    logic [15:0]     r_residue, w_res_nxt;
    logic [23:0]     r_p3, w_p3_nxt, w_ld_pix;
    logic            r_eol_pend, w_eolp_nxt;
    logic            r_run;
    logic [23:0]     r_pix;
    logic [9:0]      r_pix_x;
    logic [8:0]      r_pix_y;
    logic            r_pix_sof, r_pix_eol, r_pix_valid;
    logic [3:0]      r_err, w_err_set;
    logic            r_frame_done;
    logic [15:0]     r_frame_count;

    logic w_free, w_acc, w_load, w_hs, w_frame_end, w_at_start;
    logic w_last_word, w_early;

    assign w_free      = !r_pix_valid || pix_ready;
    assign in_stream_tready = r_run && (r_phase != EMIT3) && w_free;
    assign w_acc       = in_stream_tvalid && in_stream_tready;
    assign w_hs        = r_pix_valid && pix_ready;
    assign w_frame_end = w_hs && (r_pix_x == X_LAST) && (r_pix_y == Y_LAST);
    // The next accepted word is the expected first word of a frame.
    assign w_at_start  = (r_phase == P0) && (r_word_x == '0) && (r_x == 10'd0) && (r_y == 9'd0);

    // Next-state and pixel-load decode: a tuser word restarts the frame
    // before it is unpacked, so the effective phase/position is overridden.
    always_comb begin
        w_phase_nxt = r_phase;
        w_wx_nxt    = r_word_x;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_res_nxt   = r_residue;
        w_p3_nxt    = r_p3;
        w_eolp_nxt  = r_eol_pend;
        w_load      = 1'b0;
        w_ld_pix    = 24'd0;
        w_ld_x      = r_x;
        w_ld_y      = r_y;
        w_err_set   = 4'd0;
        w_ph        = r_phase;
        w_wx        = r_word_x;
        w_cx        = r_x;
        w_cy        = r_y;
        w_last_word = 1'b0;
        w_early     = 1'b0;
        if (w_acc) begin
            if (in_stream_tuser) begin
                w_ph = P0;
                w_wx = '0;
                w_cx = 10'd0;
                w_cy = 9'd0;
            end
            w_last_word  = (w_wx == WX_LAST);
            w_early      = in_stream_tlast && !w_last_word;
            w_err_set[0] = w_early;
            w_err_set[1] = w_last_word && !in_stream_tlast;
            w_err_set[2] = in_stream_tuser != w_at_start;
            w_err_set[3] = in_stream_tkeep != 4'hF;
            w_load       = 1'b1;
            w_ld_x       = w_cx;
            w_ld_y       = w_cy;
            w_wx_nxt     = (w_early || w_last_word) ? '0 : w_wx + 1'b1;
            w_x_nxt      = w_cx + 10'd1;
            w_y_nxt      = w_cy;
            case (w_ph)
                P0: begin
                    w_ld_pix    = in_stream_tdata[23:0];
                    w_res_nxt   = {8'd0, in_stream_tdata[31:24]};
                    w_phase_nxt = P1;
                end
                P1: begin
                    w_ld_pix    = {in_stream_tdata[15:0], r_residue[7:0]};
                    w_res_nxt   = in_stream_tdata[31:16];
                    w_phase_nxt = P2;
                end
                default: begin
                    w_ld_pix    = {in_stream_tdata[7:0], r_residue};
                    w_p3_nxt    = in_stream_tdata[31:8];
                    w_phase_nxt = EMIT3;
                    // The line ends after p3 of this word has been emitted.
                    w_eolp_nxt  = w_early || w_last_word;
                end
            endcase
            // Early tlast on a P0/P1 word: the residue is incomplete, drop it.
            if (w_early && (w_ph != P2)) begin
                w_phase_nxt = P0;
                w_x_nxt     = 10'd0;
                w_y_nxt     = next_y(w_cy);
            end
        end else if ((r_phase == EMIT3) && w_free) begin
            w_load      = 1'b1;
            w_ld_pix    = r_p3;
            w_phase_nxt = P0;
            w_eolp_nxt  = 1'b0;
            if (r_eol_pend) begin
                w_x_nxt = 10'd0;
                w_y_nxt = next_y(r_y);
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Unpacker state: phase, word position, coordinates and pixel residue.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_phase    <= P0;
            r_word_x   <= '0;
            r_x        <= 10'd0;
            r_y        <= 9'd0;
            r_residue  <= 16'd0;
            r_p3       <= 24'd0;
            r_eol_pend <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_word_x   <= w_wx_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_residue  <= w_res_nxt;
            r_p3       <= w_p3_nxt;
            r_eol_pend <= w_eolp_nxt;
            r_run      <= 1'b1;
        end
    end

    // Output pixel register: load into a free slot, otherwise drain on ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pix       <= 24'd0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 9'd0;
            r_pix_sof   <= 1'b0;
            r_pix_eol   <= 1'b0;
            r_pix_valid <= 1'b0;
        end else if (w_load) begin
            r_pix       <= w_ld_pix;
            r_pix_x     <= w_ld_x;
            r_pix_y     <= w_ld_y;
            r_pix_sof   <= (w_ld_x == 10'd0) && (w_ld_y == 9'd0);
            r_pix_eol   <= (w_ld_x == X_LAST);
            r_pix_valid <= 1'b1;
        end else if (pix_ready) begin
            r_pix_valid <= 1'b0;
        end
    end

    // Sticky error bits (set wins over clear) and frame completion tracking.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err         <= 4'd0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_err        <= (r_err & {4{!err_clr}}) | w_err_set;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

`ifdef PIXEL_UNPACK_CHECKSUM_EN
    logic [31:0] r_acc, r_sum, w_pix_ext;
    assign w_pix_ext = {8'd0, r_pix};

    // Running pixel sum restarted at (0,0), captured when the frame completes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc <= 32'd0;
            r_sum <= 32'd0;
        end else if (w_hs) begin
            r_acc <= r_pix_sof ? w_pix_ext : r_acc + w_pix_ext;
            if (w_frame_end) begin
                r_sum <= r_pix_sof ? w_pix_ext : r_acc + w_pix_ext;
            end
        end
    end
    assign frame_sum = r_sum;
`else
    assign frame_sum = 32'd0;
`endif

    assign pix_r       = r_pix[23:16];
    assign pix_g       = r_pix[15:8];
    assign pix_b       = r_pix[7:0];
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_sof     = r_pix_sof;
    assign pix_eol     = r_pix_eol;
    assign pix_valid   = r_pix_valid;
    assign err_status  = r_err;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Testbench for pixel_stream_unpacker: directed stimulus, byte-stream
// reference model, per-cycle compare process plus literal expectations.
module tb_pixel_stream_unpacker;
    localparam int X   = 160;
    localparam int Y   = 6;
    localparam int WPL = 3 * X / 4;
`ifdef PIXEL_UNPACK_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = 32'd0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0, tuser = 1'b0, tvalid = 1'b0;
    logic        tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic [3:0]  err_status;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [31:0] frame_sum;

    always #5 aclk = ~aclk;

    pixel_stream_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
        .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .err_clr(err_clr), .err_status(err_status), .frame_done(frame_done),
        .frame_count(frame_count), .frame_sum(frame_sum)
    );

    int checks = 0;
    int failures = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (byte stream view) ----------------
    typedef struct {
        logic [23:0] p;
        int          x;
        int          y;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  bq[$];
    int          mx = 0, my = 0, mwx = 0;
    logic [3:0]  m_err = 4'd0;
    int          m_fc = 0;
    logic [31:0] m_acc = 32'd0, m_sum = 32'd0;
    bit          m_fd = 1'b0;
    int          fd_cnt = 0, hs_y2 = 0, lowcnt = 0, cap_n = 0;
    logic [23:0] cap_p[4];
    int          cap_x[4];
    logic        cap_sof[4];
    logic [23:0] lh_pix = 24'd0;
    int          lh_x = -1, lh_y = -1;
    bit          held = 1'b0;
    logic [23:0] s_pix;
    logic [9:0]  s_x;
    logic [8:0]  s_y;

    function automatic logic [3:0] model_accept(input logic [31:0] d, input logic last,
                                                input logic user, input logic [3:0] keep);
        logic [3:0] set;
        exp_t e;
        logic [7:0] b0, b1, b2;
        set = 4'd0;
        if (user != ((mwx == 0) && (my == 0))) set[2] = 1'b1;
        if (keep != 4'hF) set[3] = 1'b1;
        if (user) begin
            bq.delete();
            mx = 0; my = 0; mwx = 0;
        end
        for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
        while (bq.size() >= 3) begin
            b0 = bq.pop_front(); b1 = bq.pop_front(); b2 = bq.pop_front();
            e.p = {b2, b1, b0}; e.x = mx; e.y = my;
            exp_q.push_back(e);
            mx++;
        end
        mwx++;
        if (last && (mwx < WPL)) set[0] = 1'b1;
        if (!last && (mwx == WPL)) set[1] = 1'b1;
        if (last || (mwx == WPL)) begin
            bq.delete();
            mx = 0; mwx = 0;
            my = (my == Y - 1) ? 0 : my + 1;
        end
        return set;
    endfunction

    // Compare process: registered status first, then handshake and accept.
    always @(negedge aclk) begin
        logic [3:0] set;
        exp_t e;
        if (!aresetn) begin
            exp_q.delete(); bq.delete();
            mx = 0; my = 0; mwx = 0; m_err = 4'd0; m_fc = 0;
            m_acc = 32'd0; m_sum = 32'd0; m_fd = 1'b0;
            fd_cnt = 0; hs_y2 = 0; cap_n = 0; held = 1'b0;
        end else begin
            if (!tready) lowcnt++;
            check("err_status", {28'd0, err_status}, {28'd0, m_err});
            check("frame_count", {16'd0, frame_count}, 32'(m_fc));
            check("frame_sum", frame_sum, CS_EN ? m_sum : 32'd0);
            check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
            if (frame_done) fd_cnt++;
            m_fd = 1'b0;
            if (held) begin
                check("hold_valid", {31'd0, pix_valid}, 32'd1);
                check("hold_pix", {8'd0, pix_r, pix_g, pix_b}, {8'd0, s_pix});
                check("hold_xy", {13'd0, pix_x, pix_y}, {13'd0, s_x, s_y});
            end
            held = pix_valid && !pix_ready;
            s_pix = {pix_r, pix_g, pix_b}; s_x = pix_x; s_y = pix_y;
            if (pix_valid && !pix_ready) check("stall_tready", {31'd0, tready}, 32'd0);
            if (pix_valid && pix_ready) begin
                if (cap_n < 4) begin
                    cap_p[cap_n] = {pix_r, pix_g, pix_b};
                    cap_x[cap_n] = int'(pix_x);
                    cap_sof[cap_n] = pix_sof;
                    cap_n++;
                end
                lh_pix = {pix_r, pix_g, pix_b}; lh_x = int'(pix_x); lh_y = int'(pix_y);
                if (pix_y == 9'd2) hs_y2++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pix_unexpected actual x=%0d y=%0d required none", pix_x, pix_y);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_rgb", {8'd0, pix_r, pix_g, pix_b}, {8'd0, e.p});
                    check("pix_x", {22'd0, pix_x}, 32'(e.x));
                    check("pix_y", {23'd0, pix_y}, 32'(e.y));
                    check("pix_sof", {31'd0, pix_sof}, {31'd0, (e.x == 0) && (e.y == 0)});
                    check("pix_eol", {31'd0, pix_eol}, {31'd0, e.x == X - 1});
                    m_acc = ((e.x == 0) && (e.y == 0)) ? {8'd0, e.p} : m_acc + {8'd0, e.p};
                    if ((e.x == X - 1) && (e.y == Y - 1)) begin
                        m_sum = m_acc; m_fd = 1'b1; m_fc++;
                    end
                end
            end
            set = 4'd0;
            if (tvalid && tready) set = model_accept(tdata, tlast, tuser, tkeep);
            m_err = (m_err & {4{!err_clr}}) | set;
        end
    end

    // ---------------- stimulus ----------------
    bit const_mode = 1'b0;

    function automatic logic [23:0] pix_val(input int x, input int y);
        if (const_mode) return 24'h000001;
        return 24'(y * 4099 + x * 131 + 17);
    endfunction

    function automatic logic [31:0] word_of(input int y, input int k);
        logic [23:0] p0, p1, p2, p3;
        int g;
        g = k / 3;
        p0 = pix_val(4*g, y); p1 = pix_val(4*g+1, y);
        p2 = pix_val(4*g+2, y); p3 = pix_val(4*g+3, y);
        case (k % 3)
            0:       return {p1[7:0], p0};
            1:       return {p2[15:0], p1[23:8]};
            default: return {p3, p2[23:16]};
        endcase
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic user,
                             input logic [3:0] keep);
        int n;
        bit done;
        tdata = d; tlast = last; tuser = user; tkeep = keep; tvalid = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge aclk);
            if (tready) done = 1'b1;
            n++;
        end
        check("send_accept", {31'd0, done}, 32'd1);
        @(posedge aclk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = 4'hF;
    endtask

    task automatic send_line(input int y, input int k0, input int k1, input int early_at,
                             input int user_at, input int keep_at, input bit sof);
        for (int k = k0; k < k1; k++) begin
            send_word(word_of(y, k), (k == WPL - 1) || (k == early_at),
                      ((k == 0) && sof) || (k == user_at), (k == keep_at) ? 4'h7 : 4'hF);
            if (k == early_at) break;
        end
    endtask

    task automatic send_frame();
        for (int y = 0; y < Y; y++) send_line(y, 0, WPL, -1, -1, -1, y == 0);
    endtask

    task automatic drain();
        repeat (8) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; tvalid = 1'b0; pix_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge aclk); #1;
        err_clr = 1'b0;
        check("err_after_clr", {28'd0, err_status}, 32'd0);
    endtask

    initial begin
        logic [31:0] w5;
        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tready", {31'd0, tready}, 32'd0);
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_err", {28'd0, err_status}, 32'd0);
        check("rst_fcount", {16'd0, frame_count}, 32'd0);
        check("rst_fsum", frame_sum, 32'd0);
        check("rst_xy", {13'd0, pix_x, pix_y}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("post_rst_tready", {31'd0, tready}, 32'd1);

        // Three-word unpack with hand-computed pixels
        lowcnt = 0;
        send_word(32'h44332211, 1'b0, 1'b1, 4'hF);
        send_word(32'h88776655, 1'b0, 1'b0, 4'hF);
        send_word(32'hCCBBAA99, 1'b0, 1'b0, 4'hF);
        repeat (4) @(posedge aclk);
        #1;
        check("tready_low_cycles", 32'(lowcnt), 32'd1);
        check("lit_p0", {8'd0, cap_p[0]}, 32'h332211);
        check("lit_p1", {8'd0, cap_p[1]}, 32'h665544);
        check("lit_p2", {8'd0, cap_p[2]}, 32'h998877);
        check("lit_p3", {8'd0, cap_p[3]}, 32'hCCBBAA);
        for (int i = 0; i < 4; i++) check("lit_x", 32'(cap_x[i]), 32'(i));
        check("lit_sof0", {31'd0, cap_sof[0]}, 32'd1);
        check("lit_sof1", {31'd0, cap_sof[1]}, 32'd0);
        check("lit_cnt", 32'(cap_n), 32'd4);

        // Full frame of constant pixel 1
        do_reset();
        const_mode = 1'b1;
        send_frame();
        drain();
        const_mode = 1'b0;
        check("const_err", {28'd0, err_status}, 32'd0);
        check("const_fcount", {16'd0, frame_count}, 32'd1);
        check("const_fdone_pulses", 32'(fd_cnt), 32'd1);
        check("const_fsum", frame_sum, CS_EN ? 32'd960 : 32'd0);
        check("const_queue_empty", 32'(exp_q.size()), 32'd0);

        // Early tlast on word 100 of line 1
        do_reset();
        send_line(0, 0, WPL, -1, -1, -1, 1'b1);
        send_line(1, 0, WPL, 100, -1, -1, 1'b0);
        drain();
        check("early_err", {28'd0, err_status}, 32'h1);
        check("early_last_x", 32'(lh_x), 32'd133);
        check("early_last_y", 32'(lh_y), 32'd1);
        check("early_last_pix", {8'd0, lh_pix}, {8'd0, pix_val(133, 1)});
        send_line(2, 0, 1, -1, -1, -1, 1'b0);
        drain();
        check("after_early_x", 32'(lh_x), 32'd0);
        check("after_early_y", 32'(lh_y), 32'd2);

        // Output backpressure for 10 cycles mid-line
        fork
            send_line(2, 1, WPL, -1, -1, -1, 1'b0);
            begin
                repeat (30) @(posedge aclk);
                #1 pix_ready = 1'b0;
                repeat (10) @(posedge aclk);
                #1 pix_ready = 1'b1;
            end
        join
        drain();
        check("stall_line_pixels", 32'(hs_y2), 32'(X));
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
        pulse_clr();

        // tkeep error on word 2 and stray tuser on word 5 of line 3
        send_line(3, 0, 6, -1, 5, 2, 1'b0);
        drain();
        w5 = word_of(3, 5);
        check("sof_err", {28'd0, err_status}, 32'hC);
        check("sof_pix_x", 32'(lh_x), 32'd0);
        check("sof_pix_y", 32'(lh_y), 32'd0);
        check("sof_pix_val", {8'd0, lh_pix}, {8'd0, w5[23:0]});
        pulse_clr();

        // Reset while p3 is pending, then a clean frame
        do_reset();
        send_word(word_of(0, 0), 1'b0, 1'b1, 4'hF);
        send_word(word_of(0, 1), 1'b0, 1'b0, 4'hF);
        send_word(word_of(0, 2), 1'b0, 1'b0, 4'hF);
        aresetn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, pix_valid}, 32'd0);
        check("midrst_tready", {31'd0, tready}, 32'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        send_frame();
        drain();
        check("clean_err", {28'd0, err_status}, 32'd0);
        check("clean_fcount", {16'd0, frame_count}, 32'd1);
        check("clean_fdone_pulses", 32'(fd_cnt), 32'd1);
        check("clean_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
